// File: rtl/regfile_bank.sv
// regfile_bank: register bank written through a one-hot select from a
// 5-to-32 decoder, with two combinational read ports. Register 0 reads as
// zero. A malformed select sets a sticky error flag, and committed writes
// are counted with saturation.
// Optional feature: define REGFILE_BYPASS_EN for write-through forwarding
// of a pending commit onto the read ports.
module regfile_bank #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              ctrl_writeEnable,
    input  logic [NREGS-1:0]  data_decd,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    output logic              sel_error,
    output logic [15:0]       write_count
);

    localparam logic [NREGS-1:0] ONE = {{(NREGS-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs [NREGS];
    logic              sel_onehot;
    logic              commit;
    logic              commit_nz;

    // A select is valid only with exactly one bit set; a write to register 0
    // is accepted but neither stores nor counts.
    always_comb begin
        sel_onehot = (data_decd != '0) && ((data_decd & (data_decd - ONE)) == '0);
        commit     = ctrl_writeEnable && sel_onehot;
        commit_nz  = commit && !data_decd[0];
    end

    // Register storage; register 0 is only ever cleared so it stays zero.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit_nz) begin
            for (int i = 1; i < NREGS; i++) begin
                if (data_decd[i]) begin
                    regs[i] <= data_writeReg;
                end
            end
        end
    end

    // Sticky flag for an enabled write with a non-one-hot select.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            sel_error <= 1'b0;
        end else if (ctrl_writeEnable && !sel_onehot) begin
            sel_error <= 1'b1;
        end
    end

    // Saturating count of writes that actually updated a register.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            write_count <= '0;
        end else if (commit_nz && (write_count != 16'hFFFF)) begin
            write_count <= write_count + 16'd1;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        if (addr == '0) begin
            val = '0;
        end else begin
            val = regs[addr];
`ifdef REGFILE_BYPASS_EN
            // Only a real commit is forwarded; commit_nz already excludes
            // malformed selects and a disabled write.
            if (commit_nz && data_decd[addr]) begin
                val = data_writeReg;
            end
`endif
        end
        return val;
    endfunction

    // Zero-latency read muxes.
    always_comb begin
        data_readRegA = read_port(ctrl_readRegA);
        data_readRegB = read_port(ctrl_readRegB);
    end

endmodule
